// File: rtl/bitserial_pkg.sv
// Shared types for the digit-serial logic processor.
//   func_t  : 3-bit function select applied bitwise to the outgoing low digits
//   route_t : 2-bit routing select choosing what re-enters the top of A and B
//   state_t : control FSM states
package bitserial_pkg;

    typedef enum logic [2:0] {
        FN_AND   = 3'b000,
        FN_OR    = 3'b001,
        FN_XOR   = 3'b010,
        FN_ONES  = 3'b011,
        FN_NAND  = 3'b100,
        FN_NOR   = 3'b101,
        FN_XNOR  = 3'b110,
        FN_ZEROS = 3'b111
    } func_t;

    typedef enum logic [1:0] {
        RT_ROTATE = 2'b00,  // newA = A digit, newB = B digit
        RT_TO_B   = 2'b01,  // newA = A digit, newB = fa
        RT_TO_A   = 2'b10,  // newA = fa,      newB = B digit
        RT_SWAP   = 2'b11   // newA = B digit, newB = A digit
    } route_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/bitserial_digit_alu.sv
// Combinational function/routing unit for one digit.
//   f, r         : captured function and routing selects
//   a_dig, b_dig : low DIGIT bits leaving registers A and B
//   new_a, new_b : DIGIT bits to insert at the top of A and B
module bitserial_digit_alu
    import bitserial_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  func_t              f,
    input  route_t             r,
    input  logic [DIGIT-1:0]   a_dig,
    input  logic [DIGIT-1:0]   b_dig,
    output logic [DIGIT-1:0]   new_a,
    output logic [DIGIT-1:0]   new_b
);

    logic [DIGIT-1:0] fa;

    always_comb begin
        fa = '0;
        unique case (f)
            FN_AND:   fa = a_dig & b_dig;
            FN_OR:    fa = a_dig | b_dig;
            FN_XOR:   fa = a_dig ^ b_dig;
            FN_ONES:  fa = '1;
            FN_NAND:  fa = ~(a_dig & b_dig);
            FN_NOR:   fa = ~(a_dig | b_dig);
            FN_XNOR:  fa = ~(a_dig ^ b_dig);
            FN_ZEROS: fa = '0;
            default:  fa = '0;
        endcase
    end

    always_comb begin
        new_a = a_dig;
        new_b = b_dig;
        unique case (r)
            RT_ROTATE: begin new_a = a_dig; new_b = b_dig; end
            RT_TO_B:   begin new_a = a_dig; new_b = fa;    end
            RT_TO_A:   begin new_a = fa;    new_b = b_dig; end
            RT_SWAP:   begin new_a = b_dig; new_b = a_dig; end
            default:   begin new_a = a_dig; new_b = b_dig; end
        endcase
    end

endmodule

// File: rtl/bitserial_processor.sv
// Digit-serial logic processor with two WIDTH-bit registers A and B.
// Execute captures F/R and then shifts both registers right DIGIT bits per
// clock for WIDTH/DIGIT cycles, refilling the top digits via the digit ALU.
// Ports:
//   Clk, Reset (sync, active-high)
//   LoadA, LoadB, Din : parallel load in IDLE (load beats Execute)
//   Execute           : level start; one operation per assertion
//   F, R              : function / routing select, captured at start
//   A, B              : register contents
//   Busy              : high while shifting
//   Done              : one-cycle pulse after the final shift
//   OpCount [7:0]     : saturating count of completed operations, present
//                       only when BITSERIAL_OPCOUNT_EN is defined
module bitserial_processor
    import bitserial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done
`ifdef BITSERIAL_OPCOUNT_EN
    ,
    output logic [7:0]       OpCount
`endif
);

    localparam int unsigned NSHIFT = WIDTH / DIGIT;
    localparam int unsigned CW     = $clog2(NSHIFT + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    func_t            f_q, f_d;
    route_t           r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] new_a, new_b;

    bitserial_digit_alu #(
        .DIGIT (DIGIT)
    ) u_alu (
        .f     (f_q),
        .r     (r_q),
        .a_dig (a_q[DIGIT-1:0]),
        .b_dig (b_q[DIGIT-1:0]),
        .new_a (new_a),
        .new_b (new_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        r_d     = r_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (LoadA) a_d = Din;
                if (LoadB) b_d = Din;
                if (Execute && !LoadA && !LoadB) begin
                    f_d     = func_t'(F);
                    r_d     = route_t'(R);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Shift first, then overwrite the top digit; this form stays
                // legal when DIGIT == WIDTH.
                a_d = a_q >> DIGIT;
                b_d = b_q >> DIGIT;
                a_d[WIDTH-1 -: DIGIT] = new_a;
                b_d[WIDTH-1 -: DIGIT] = new_b;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NSHIFT - 1)) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!Execute) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= FN_AND;
            r_q     <= RT_ROTATE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign Busy = busy_q;
    assign Done = done_q;

`ifdef BITSERIAL_OPCOUNT_EN
    logic [7:0] opcount_q, opcount_d;

    always_comb begin
        opcount_d = opcount_q;
        if (done_q && (opcount_q != 8'hFF)) opcount_d = opcount_q + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) opcount_q <= '0;
        else       opcount_q <= opcount_d;
    end

    assign OpCount = opcount_q;
`endif

endmodule

// File: tb/tb_bitserial_processor.sv
// Bench for bitserial_processor: two instances (DIGIT=1 and DIGIT=4, WIDTH=8)
// share all inputs; results are predicted from whole-word logic operations.
module tb_bitserial_processor;

    logic       Clk = 1'b0;
    logic       Reset, LoadA, LoadB, Execute;
    logic [7:0] Din;
    logic [2:0] F;
    logic [1:0] R;
    logic [7:0] A1, B1, A4, B4;
    logic       Busy1, Done1, Busy4, Done4;
`ifdef BITSERIAL_OPCOUNT_EN
    logic [7:0] OpCount1, OpCount4;
`endif

    always #5 Clk = ~Clk;

    bitserial_processor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB),
        .Execute(Execute), .Din(Din), .F(F), .R(R),
        .A(A1), .B(B1), .Busy(Busy1), .Done(Done1)
`ifdef BITSERIAL_OPCOUNT_EN
        , .OpCount(OpCount1)
`endif
    );

    bitserial_processor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB),
        .Execute(Execute), .Din(Din), .F(F), .R(R),
        .A(A4), .B(B4), .Busy(Busy4), .Done(Done4)
`ifdef BITSERIAL_OPCOUNT_EN
        , .OpCount(OpCount4)
`endif
    );

    int total = 0;
    int bad   = 0;
    int ops   = 0;
    logic [7:0] ma = 8'h00;
    logic [7:0] mb = 8'h00;

    function automatic logic [7:0] word_fn(input logic [2:0] f,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return 8'hFF;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_a1"}, 32'(A1), 32'(ma));
        check({tag, "_b1"}, 32'(B1), 32'(mb));
        check({tag, "_a4"}, 32'(A4), 32'(ma));
        check({tag, "_b4"}, 32'(B4), 32'(mb));
    endtask

    task automatic load(input logic la, input logic lb, input logic [7:0] d);
        LoadA = la; LoadB = lb; Din = d;
        @(negedge Clk);
        LoadA = 1'b0; LoadB = 1'b0;
        if (la) ma = d;
        if (lb) mb = d;
        check_regs("load");
    endtask

    // Hold Execute for `hold` cycles, scrambling F/R/Din after the start edge,
    // optionally pulsing LoadA=0xFF mid-operation.
    task automatic run_op(input logic [2:0] f, input logic [1:0] r,
                          input int hold, input bit inject);
        logic [7:0] fa, ea, eb;
        int nb1, nb4, nd1, nd4;
        fa = word_fn(f, ma, mb);
        case (r)
            2'd0: begin ea = ma; eb = mb; end
            2'd1: begin ea = ma; eb = fa; end
            2'd2: begin ea = fa; eb = mb; end
            default: begin ea = mb; eb = ma; end
        endcase
        nb1 = 0; nb4 = 0; nd1 = 0; nd4 = 0;
        F = f; R = r; Execute = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (Busy1) nb1++;
            if (Busy4) nb4++;
            if (Done1) begin nd1++; check("done_a1", 32'(A1), 32'(ea)); end
            if (Done4) begin nd4++; check("done_a4", 32'(A4), 32'(ea)); end
            F   = 3'($urandom);
            R   = 2'($urandom);
            Din = 8'($urandom);
            if (inject && i == 2) begin LoadA = 1'b1; Din = 8'hFF; end
            else LoadA = 1'b0;
        end
        LoadA = 1'b0;
        Execute = 1'b0;
        @(negedge Clk);
        ma = ea; mb = eb;
        ops++;
        check_regs("op");
        check("busy_cycles1", 32'(nb1), 32'd8);
        check("busy_cycles4", 32'(nb4), 32'd2);
        check("done_pulses1", 32'(nd1), 32'd1);
        check("done_pulses4", 32'(nd4), 32'd1);
`ifdef BITSERIAL_OPCOUNT_EN
        check("opcount1", 32'(OpCount1), (ops > 255) ? 32'd255 : 32'(ops));
        check("opcount4", 32'(OpCount4), (ops > 255) ? 32'd255 : 32'(ops));
`endif
    endtask

    initial begin
        int nb, nd;
        Reset = 1'b1; LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b0;
        Din = 8'h00; F = 3'd0; R = 2'd0;
        @(negedge Clk);
        @(negedge Clk);
        check_regs("reset");
        check("reset_busy1", 32'(Busy1), 32'd0);
        check("reset_done1", 32'(Done1), 32'd0);
        check("reset_busy4", 32'(Busy4), 32'd0);
        check("reset_done4", 32'(Done4), 32'd0);
`ifdef BITSERIAL_OPCOUNT_EN
        check("reset_opcount1", 32'(OpCount1), 32'd0);
`endif
        Reset = 1'b0;

        // XOR routed into A, Execute held long: exactly one operation
        load(1'b1, 1'b0, 8'h33);
        load(1'b0, 1'b1, 8'h55);
        run_op(3'b010, 2'b10, 20, 1'b0);
        check("xor_a_const", 32'(A1), 32'h66);

        // AND into B, then swap (with a mid-shift LoadA), then rotate
        load(1'b1, 1'b0, 8'h33);
        load(1'b0, 1'b1, 8'h55);
        run_op(3'b000, 2'b01, 14, 1'b0);
        run_op(3'($urandom), 2'b11, 14, 1'b1);
        check("swap_b_const", 32'(B1), 32'h33);
        run_op(3'($urandom), 2'b00, 14, 1'b0);

        // Load together with Execute in IDLE: load wins, no start
        LoadA = 1'b1; Execute = 1'b1; Din = 8'hA5;
        @(negedge Clk);
        LoadA = 1'b0; Execute = 1'b0;
        ma = 8'hA5;
        check_regs("load_exec");
        check("load_exec_busy1", 32'(Busy1), 32'd0);
        check("load_exec_busy4", 32'(Busy4), 32'd0);
        @(negedge Clk);
        check("load_exec_busy1_b", 32'(Busy1), 32'd0);
        check("load_exec_busy4_b", 32'(Busy4), 32'd0);

        // Reset on the edge of shift 3 of 8 aborts the operation
        load(1'b0, 1'b1, 8'h3C);
        F = 3'b010; R = 2'b10; Execute = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b1; Execute = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        ma = 8'h00; mb = 8'h00;
        check_regs("abort");
        check("abort_busy1", 32'(Busy1), 32'd0);
        check("abort_done1", 32'(Done1), 32'd0);
        nb = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Busy1 || Busy4) nb++;
            if (Done1 || Done4) nd++;
        end
        check("abort_no_busy", 32'(nb), 32'd0);
        check("abort_no_done", 32'(nd), 32'd0);
`ifdef BITSERIAL_OPCOUNT_EN
        ops = 0;
        check("abort_opcount1", 32'(OpCount1), 32'd0);
`endif

        // Random operations
        for (int k = 0; k < 8; k++) begin
            load(1'b1, 1'b0, 8'($urandom));
            load(1'b0, 1'b1, 8'($urandom));
            run_op(3'($urandom), 2'($urandom), int'($urandom_range(12, 20)),
                   (k % 3) == 0);
        end

`ifdef BITSERIAL_OPCOUNT_EN
        while (ops < 260) run_op(3'($urandom), 2'($urandom), 12, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
